// File: rtl/mem_req_ctrl.sv
// Request controller in front of single_port_mem: buffers tagged LSQ requests in an
// in-order FIFO, runs one issue/wait memory transaction at a time, returns tagged completions.
module mem_req_ctrl #(
    parameter int ADDR_WIDTH = 20,
    parameter int TAG_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic                  resp_is_store,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_data_in,
    input  logic [31:0]           mem_data_out,
    output logic                  mem_cs,
    output logic                  mem_wr,
    output logic                  mem_re,
    input  logic                  mem_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic                  is_store;
        logic [TAG_WIDTH-1:0]  tag;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           wdata;
    } req_t;

    req_t                 r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    state_t               r_state;
    logic [TMO_W-1:0]     r_tmo;
    logic                 r_inf_store;
    logic [TAG_WIDTH-1:0] r_inf_tag;

    logic w_push;
    logic w_pop;
    req_t w_in;
    req_t w_head;

    // Ready comes straight from registered occupancy, so a same-edge pop cannot raise it early.
    assign req_ready = (r_count != FULL_CNT);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != {CNT_W{1'b0}});
    assign w_head    = r_fifo[r_rd_ptr];
    assign w_in      = '{is_store: req_is_store, tag: req_tag, addr: req_addr, wdata: req_wdata};

    // FIFO storage and pointers; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_in;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Transaction FSM with registered memory strobes and completion outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_tmo         <= {TMO_W{1'b0}};
            r_inf_store   <= 1'b0;
            r_inf_tag     <= {TAG_WIDTH{1'b0}};
            mem_address   <= {ADDR_WIDTH{1'b0}};
            mem_data_in   <= 32'd0;
            mem_cs        <= 1'b0;
            mem_wr        <= 1'b0;
            mem_re        <= 1'b0;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_is_store <= 1'b0;
            resp_tag      <= {TAG_WIDTH{1'b0}};
            resp_rdata    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_inf_store <= w_head.is_store;
                        r_inf_tag   <= w_head.tag;
                        mem_address <= w_head.addr;
                        mem_data_in <= w_head.is_store ? w_head.wdata : 32'd0;
                        mem_cs      <= 1'b1;
                        mem_wr      <= w_head.is_store;
                        mem_re      <= !w_head.is_store;
                        r_state     <= S_ISSUE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    mem_wr  <= 1'b0;
                    mem_re  <= 1'b0;
                    r_tmo   <= {TMO_W{1'b0}};
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_done) begin
                        resp_valid    <= 1'b1;
                        resp_err      <= 1'b0;
                        resp_tag      <= r_inf_tag;
                        resp_is_store <= r_inf_store;
                        resp_rdata    <= r_inf_store ? 32'd0 : mem_data_out;
                        mem_cs        <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (r_tmo == TMO_LAST) begin
                        resp_valid    <= 1'b1;
                        resp_err      <= 1'b1;
                        resp_tag      <= r_inf_tag;
                        resp_is_store <= r_inf_store;
                        resp_rdata    <= 32'd0;
                        mem_cs        <= 1'b0;
                        r_state       <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_RESP: begin
                    // Completion fields stay frozen until the core takes them.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    mem_cs     <= 1'b0;
                    mem_wr     <= 1'b0;
                    mem_re     <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a small behavioural memory and a completion log.
module tb_mem_req_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [19:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_tag;
    logic        resp_is_store;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [19:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_cs;
    logic        mem_wr;
    logic        mem_re;
    logic        mem_done;

    int n_asrt = 0;
    int n_fail = 0;

    mem_req_ctrl #(.ADDR_WIDTH(20), .TAG_WIDTH(4), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
        .resp_is_store(resp_is_store), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_re(mem_re), .mem_done(mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: unwritten words read as 0xA0000000 + address.
    int          mem_lat = 3;
    bit          mute = 1'b0;
    logic        spur_done = 1'b0;
    logic        m_done;
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_dout;
    logic [31:0] m_mem [16];
    logic        m_wrt [16];

    assign mem_done     = m_done | spur_done;
    assign mem_data_out = spur_done ? 32'hDEAD_BEEF : m_dout;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_dout <= 32'd0;
            for (int i = 0; i < 16; i++) m_wrt[i] <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_cnt <= 1) begin
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (mem_cs && (mem_wr || mem_re) && !mute) begin
                if (mem_wr) begin
                    m_mem[mem_address[3:0]] <= mem_data_in;
                    m_wrt[mem_address[3:0]] <= 1'b1;
                end else begin
                    m_dout <= m_wrt[mem_address[3:0]] ? m_mem[mem_address[3:0]]
                                                      : (32'hA000_0000 | {28'd0, mem_address[3:0]});
                end
                m_busy <= 1'b1;
                m_cnt  <= mem_lat;
            end
        end
    end

    // Completion log {err, is_store, tag, rdata} and strobe cycle counters.
    logic [37:0] log_q [$];
    int wr_cycles = 0;
    int re_cycles = 0;
    int cs_cycles = 0;

    always @(posedge clk) begin
        if (rst && resp_valid && resp_ready) log_q.push_back({resp_err, resp_is_store, resp_tag, resp_rdata});
        if (mem_wr) wr_cycles <= wr_cycles + 1;
        if (mem_re) re_cycles <= re_cycles + 1;
        if (mem_cs) cs_cycles <= cs_cycles + 1;
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic st, input logic [19:0] a, input logic [31:0] d, input logic [3:0] t);
        int n = 0;
        req_valid    = 1'b1;
        req_is_store = st;
        req_addr     = a;
        req_wdata    = d;
        req_tag      = t;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        chk("push_accepted", {63'd0, req_ready}, 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_log(input int cnt);
        int n = 0;
        while (log_q.size() < cnt && n < 500) begin
            tick();
            n++;
        end
        chk("log_count", 64'(log_q.size()), 64'(cnt));
    endtask

    task automatic chk_log(input int idx, input logic err, input logic st, input logic [3:0] t, input logic [31:0] d);
        logic [37:0] e;
        e = log_q[idx];
        chk("resp_tag_order", {60'd0, e[35:32]}, {60'd0, t});
        chk("resp_fields", {26'd0, e}, {26'd0, err, st, t, d});
    endtask

    initial begin
        int n;
        int wr0, re0, cs0;
        rst = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_addr = 20'd0;
        req_wdata = 32'd0; req_tag = 4'd0; resp_ready = 1'b1;
        #12;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_strobes", {58'd0, resp_valid, resp_err, resp_is_store, mem_cs, mem_wr, mem_re}, 64'd0);
        chk("rst_resp_data", {28'd0, resp_tag, resp_rdata}, 64'd0);
        chk("rst_mem_bus", {12'd0, mem_address, mem_data_in}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Store then load to the same word.
        wr0 = wr_cycles; re0 = re_cycles;
        push(1'b1, 20'h1, 32'h5, 4'd2);
        tick();
        chk("issue_store", {10'd0, mem_cs, mem_wr, mem_re, mem_address, mem_data_in}, {10'd0, 1'b1, 1'b1, 1'b0, 20'h1, 32'h5});
        push(1'b0, 20'h1, 32'h0, 4'd3);
        chk("wait_strobes", {61'd0, mem_cs, mem_wr, mem_re}, {61'd0, 3'b100});
        wait_log(2);
        chk_log(0, 1'b0, 1'b1, 4'd2, 32'h0);
        chk_log(1, 1'b0, 1'b0, 4'd3, 32'h5);
        chk("wr_pulse_cycles", 64'(wr_cycles - wr0), 64'd1);
        chk("re_pulse_cycles", 64'(re_cycles - re0), 64'd1);

        // Six back-to-back loads against a slow memory fill the FIFO.
        log_q.delete();
        mem_lat = 10;
        for (int i = 0; i < 5; i++) push(1'b0, 20'(i + 2), 32'd0, 4'(i));
        chk("full_ready_low", {63'd0, req_ready}, 64'd0);
        push(1'b0, 20'h7, 32'd0, 4'd5);
        chk("sixth_after_first_done", 64'(log_q.size()), 64'd1);
        wait_log(6);
        for (int i = 0; i < 6; i++) chk_log(i, 1'b0, 1'b0, 4'(i), 32'hA000_0000 + 32'(i + 2));

        // Response backpressure with a second load queued behind.
        log_q.delete();
        mem_lat = 3;
        resp_ready = 1'b0;
        push(1'b0, 20'h3, 32'd0, 4'd9);
        push(1'b0, 20'h2, 32'd0, 4'd10);
        n = 0;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold", {27'd0, resp_valid, resp_tag, resp_rdata}, {27'd0, 1'b1, 4'd9, 32'hA000_0003});
            chk("bp_no_issue", {63'd0, mem_cs}, 64'd0);
            if (k < 2) tick();
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_idle", {62'd0, resp_valid, mem_cs}, 64'd0);
        tick();
        chk("bp_next_issue", {42'd0, mem_cs, mem_re, mem_address}, {42'd0, 1'b1, 1'b1, 20'h2});
        wait_log(2);
        chk_log(0, 1'b0, 1'b0, 4'd9, 32'hA000_0003);
        chk_log(1, 1'b0, 1'b0, 4'd10, 32'hA000_0002);

        // Timeout on a silent memory, then normal service of the next request.
        log_q.delete();
        mute = 1'b1;
        push(1'b0, 20'h4, 32'd0, 4'd7);
        tick();
        chk("tmo_issue", {63'd0, mem_re}, 64'd1);
        push(1'b0, 20'h5, 32'd0, 4'd8);
        n = 1;
        while (!resp_valid && n < 200) begin
            tick();
            n++;
        end
        chk("tmo_wait_cycles", 64'(n - 1), 64'd64);
        chk("tmo_resp", {27'd0, resp_err, resp_tag, resp_rdata}, {27'd0, 1'b1, 4'd7, 32'd0});
        mute = 1'b0;
        wait_log(2);
        chk_log(0, 1'b1, 1'b0, 4'd7, 32'd0);
        chk_log(1, 1'b0, 1'b0, 4'd8, 32'hA000_0005);

        // Asynchronous reset while waiting with two requests queued.
        log_q.delete();
        mem_lat = 10;
        push(1'b0, 20'h2, 32'd0, 4'd1);
        tick();
        push(1'b0, 20'h3, 32'd0, 4'd2);
        push(1'b0, 20'h4, 32'd0, 4'd3);
        tick();
        chk("pre_rst_wait", {63'd0, mem_cs}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_cs", {62'd0, mem_cs, req_ready}, 64'd1);
        #20;
        @(negedge clk);
        rst = 1'b1;
        cs0 = cs_cycles;
        repeat (30) tick();
        chk("post_rst_no_resp", 64'(log_q.size()), 64'd0);
        chk("post_rst_no_issue", 64'(cs_cycles - cs0), 64'd0);
        chk("post_rst_state", {62'd0, resp_valid, req_ready}, 64'd1);

        // Spurious mem_done in RESP and in IDLE.
        mem_lat = 3;
        resp_ready = 1'b0;
        push(1'b0, 20'h6, 32'd0, 4'd4);
        n = 0;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        chk("spur_resp", {26'd0, resp_valid, mem_cs, resp_tag, resp_rdata}, {26'd0, 1'b1, 1'b0, 4'd4, 32'hA000_0006});
        resp_ready = 1'b1;
        wait_log(1);
        cs0 = cs_cycles;
        tick();
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        tick();
        chk("spur_idle", {30'd0, resp_valid, mem_cs, resp_rdata}, {30'd0, 1'b0, 1'b0, 32'hA000_0006});
        chk("spur_idle_no_issue", 64'(cs_cycles - cs0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
